// File: rtl/hex_rotate_monitor.sv
// Read-back checker for the rotating "0 1 E d" seven-segment banner.
// Debounces the HEX buses, recovers the rotation position and polices single forward steps.
module hex_rotate_monitor #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned DW            = 24
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic [6:0]    HEX0,
  input  logic [6:0]    HEX1,
  input  logic [6:0]    HEX2,
  input  logic [6:0]    HEX3,
  input  logic [6:0]    HEX4,
  input  logic [6:0]    HEX5,
  input  logic [6:0]    HEX6,
  input  logic [6:0]    HEX7,
  input  logic          CLR_FAULT,
  output logic          VALID,
  output logic [2:0]    POS,
  output logic          LOCKED,
  output logic          FAULT,
  output logic [1:0]    FAULT_CODE,
  output logic [15:0]   STEP_CNT,
  output logic [DW-1:0] LAST_DWELL
);

  localparam int unsigned NDIG = 8;
  localparam int unsigned SW   = 7;
  localparam int unsigned FW   = NDIG * SW;
  localparam int unsigned CW   = 4;

  localparam logic [CW-1:0] STABLE    = CW'(STABLE_CYCLES);
  localparam logic [SW-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SW-1:0] SEG_0     = 7'b1000000;
  localparam logic [SW-1:0] SEG_1     = 7'b1111001;
  localparam logic [SW-1:0] SEG_E     = 7'b0000110;
  localparam logic [SW-1:0] SEG_D     = 7'b0100001;
  localparam logic [2:0]    SYM_BLANK = 3'd4;
  localparam logic [2:0]    SYM_BAD   = 3'd7;
  localparam logic [DW-1:0] DWELL_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  // Symbol code: 0..3 = character index, 4 = blank, 7 = unrecognised pattern.
  function automatic logic [2:0] decode(input logic [SW-1:0] seg);
    logic [2:0] sym;
    case (seg)
      SEG_BLANK: sym = SYM_BLANK;
      SEG_0:     sym = 3'd0;
      SEG_1:     sym = 3'd1;
      SEG_E:     sym = 3'd2;
      SEG_D:     sym = 3'd3;
      default:   sym = SYM_BAD;
    endcase
    return sym;
  endfunction

  logic [FW-1:0]             in_d, in_q, acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      accept;
  logic [NDIG-1:0][2:0]      sym;
  logic                      hit;
  logic [2:0]                hit_pos;
  logic [2:0]                m_c, m_exp;
  logic                      m_ok;
  state_t                    state_q, state_d;
  logic [DW-1:0]             dwell_q, dwell_d;
  logic                      valid_d, locked_d, fault_d;
  logic [2:0]                pos_d, pos_inc;
  logic [1:0]                code_d;
  logic [15:0]               step_d;
  logic [DW-1:0]             ldw_d;

  assign in_d    = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign pos_inc = POS + 3'd1;

  // Stability filter: acceptance uses the post-edge frame so outputs move on the accepting edge.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    accept = 1'b0;
    if (in_d != in_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + CW'(1);
    end
    if ((cnt_d == STABLE) && (in_d != acc_q)) begin
      acc_d  = in_d;
      accept = 1'b1;
    end
  end

  // Match the accepted frame against the eight canonical rotations.
  always_comb begin
    hit     = 1'b0;
    hit_pos = 3'd0;
    m_c     = 3'd0;
    m_exp   = 3'd0;
    m_ok    = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      sym[k] = decode(acc_d[k*SW +: SW]);
    end
    for (int s = 0; s < NDIG; s++) begin
      m_ok = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
        m_c   = 3'(s + k);
        m_exp = m_c[2] ? SYM_BLANK : m_c;
        if (sym[k] != m_exp) m_ok = 1'b0;
      end
      if (m_ok) begin
        hit     = 1'b1;
        hit_pos = 3'(s);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    valid_d = VALID;
    pos_d   = POS;
    code_d  = FAULT_CODE;
    step_d  = STEP_CNT;
    ldw_d   = LAST_DWELL;
    case (state_q)
      ST_SEARCH: begin
        if (hit) begin
          state_d = ST_TRACK;
          pos_d   = hit_pos;
          valid_d = 1'b1;
          step_d  = 16'd0;
          dwell_d = '0;
        end
      end
      ST_TRACK: begin
        dwell_d = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + DW'(1);
        if (accept) begin
          if (!hit) begin
            state_d = ST_FAULT;
            code_d  = 2'b01;
            valid_d = 1'b0;
          end else if (hit_pos == pos_inc) begin
            pos_d   = hit_pos;
            step_d  = STEP_CNT + 16'd1;
            ldw_d   = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + DW'(1);
            dwell_d = '0;
          end else begin
            state_d = ST_FAULT;
            code_d  = 2'b10;
          end
        end
      end
      ST_FAULT: begin
        if (CLR_FAULT) begin
          state_d = ST_SEARCH;
          code_d  = 2'b00;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_d == ST_TRACK);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      in_q       <= '1;
      acc_q      <= '1;
      cnt_q      <= '0;
      state_q    <= ST_SEARCH;
      dwell_q    <= '0;
      VALID      <= 1'b0;
      POS        <= 3'd0;
      LOCKED     <= 1'b0;
      FAULT      <= 1'b0;
      FAULT_CODE <= 2'b00;
      STEP_CNT   <= 16'd0;
      LAST_DWELL <= '0;
    end else begin
      in_q       <= in_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      VALID      <= valid_d;
      POS        <= pos_d;
      LOCKED     <= locked_d;
      FAULT      <= fault_d;
      FAULT_CODE <= code_d;
      STEP_CNT   <= step_d;
      LAST_DWELL <= ldw_d;
    end
  end

endmodule
